// File: rtl/sram_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl_if
// Purpose  : Single-request bus between a master and the SRAM controller.
// Revision : 1.0  initial release
// ============================================================================
interface sram_ctrl_if;
  logic        req;
  logic        we;
  logic [1:0]  size;
  logic [18:0] addr;
  logic [31:0] wdata;
  logic        ready;
  logic [31:0] rdata;
  logic        err;

  modport master (output req, we, size, addr, wdata, input  ready, rdata, err);
  modport slave  (input  req, we, size, addr, wdata, output ready, rdata, err);
endinterface
`default_nettype wire

// File: rtl/sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sram_ctrl
// Purpose  : Splits 1/2/4-byte bus requests into timed little-endian byte
//            cycles on a 512K x 8 asynchronous SRAM. Optional alignment
//            checking is enabled with SRAM_CTRL_ALIGN_CHK_EN.
// Revision : 1.0  initial release
// ============================================================================
`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif
`ifndef IOR_DIR_IN
`define IOR_DIR_IN 1'b0
`endif

module sram_ctrl #(
  parameter int ACCESS_CYCLES  = 2,
  parameter int WR_HOLD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rstn,
  sram_ctrl_if.slave  bus,
  output logic        sram_ce_bar,
  output logic        sram_oe_bar,
  output logic        sram_we_bar,
  output logic        sram_data_dir,
  output logic [7:0]  sram_data_out,
  input  logic [7:0]  sram_data_in,
  output logic [18:0] sram_addr
);

  localparam logic [3:0] ACC_LAST  = 4'(ACCESS_CYCLES - 1);
  localparam logic [3:0] HOLD_LAST = 4'(WR_HOLD_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_RD_ACC, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  n_q, n_d;
  logic        we_q, we_d;
  logic [18:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ready_q, ready_d;
  logic        err_q, err_d;
  logic        ce_q, ce_d, oe_q, oe_d, wbar_q, wbar_d, dir_q, dir_d;
  logic [7:0]  dout_q, dout_d;
  logic [18:0] addr_q, addr_d;
  logic [7:0]  wbyte;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    k_d     = k_q;
    n_d     = n_q;
    we_d    = we_q;
    base_d  = base_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          base_d  = bus.addr;
          wdata_d = bus.wdata;
          rdata_d = 32'd0;
          k_d     = 3'd0;
          cnt_d   = 4'd0;
          case (bus.size)
            2'd0:    n_d = 3'd1;
            2'd1:    n_d = 3'd2;
            default: n_d = 3'd4;
          endcase
`ifdef SRAM_CTRL_ALIGN_CHK_EN
          if ((bus.size == 2'd1 && bus.addr[0]) ||
              (bus.size[1] && bus.addr[1:0] != 2'd0)) begin
            state_d = S_DONE;
            err_d   = 1'b1;
          end else
`endif
          if (bus.we) state_d = S_WR_SETUP;
          else        state_d = S_RD_ACC;
        end
      end
      S_RD_ACC: begin
        if (cnt_q == ACC_LAST) begin
          case (k_q[1:0])
            2'd0: rdata_d[7:0]   = sram_data_in;
            2'd1: rdata_d[15:8]  = sram_data_in;
            2'd2: rdata_d[23:16] = sram_data_in;
            default: rdata_d[31:24] = sram_data_in;
          endcase
          cnt_d = 4'd0;
          k_d   = k_q + 3'd1;
          if (k_d == n_q) state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR_SETUP: begin
        cnt_d   = 4'd0;
        state_d = S_WR_PULSE;
      end
      S_WR_PULSE: begin
        if (cnt_q == ACC_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_WR_HOLD;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_WR_HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          cnt_d   = 4'd0;
          k_d     = k_q + 3'd1;
          state_d = (k_d == n_q) ? S_DONE : S_WR_SETUP;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Pad-side signals are registered from the next state so strobes are glitch-free.
    case (k_d[1:0])
      2'd0:    wbyte = wdata_d[7:0];
      2'd1:    wbyte = wdata_d[15:8];
      2'd2:    wbyte = wdata_d[23:16];
      default: wbyte = wdata_d[31:24];
    endcase
    ready_d = (state_d == S_DONE);
    ce_d    = (state_d == S_IDLE) || (state_d == S_DONE);
    oe_d    = (state_d != S_RD_ACC);
    wbar_d  = (state_d != S_WR_PULSE);
    dir_d   = (state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD}) ? `IOR_DIR_OUT : `IOR_DIR_IN;
    addr_d  = (state_d == S_RD_ACC || state_d == S_WR_SETUP) ? (base_d + {16'd0, k_d}) : addr_q;
    dout_d  = (state_d == S_WR_SETUP) ? wbyte : dout_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      k_q     <= 3'd0;
      n_q     <= 3'd0;
      we_q    <= 1'b0;
      base_q  <= 19'd0;
      wdata_q <= 32'd0;
      rdata_q <= 32'd0;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
      ce_q    <= 1'b1;
      oe_q    <= 1'b1;
      wbar_q  <= 1'b1;
      dir_q   <= `IOR_DIR_IN;
      dout_q  <= 8'd0;
      addr_q  <= 19'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      k_q     <= k_d;
      n_q     <= n_d;
      we_q    <= we_d;
      base_q  <= base_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      ready_q <= ready_d;
      err_q   <= err_d;
      ce_q    <= ce_d;
      oe_q    <= oe_d;
      wbar_q  <= wbar_d;
      dir_q   <= dir_d;
      dout_q  <= dout_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.ready     = ready_q;
  assign bus.rdata     = rdata_q;
  assign bus.err       = err_q;
  assign sram_ce_bar   = ce_q;
  assign sram_oe_bar   = oe_q;
  assign sram_we_bar   = wbar_q;
  assign sram_data_dir = dir_q;
  assign sram_data_out = dout_q;
  assign sram_addr     = addr_q;

endmodule
`default_nettype wire

// File: tb/tb_sram_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_ctrl
// Purpose  : Randomized self-checking bench for sram_ctrl with an SRAM model.
// Revision : 1.0  initial release
// ============================================================================
`ifndef IOR_DIR_OUT
`define IOR_DIR_OUT 1'b1
`endif
`ifndef IOR_DIR_IN
`define IOR_DIR_IN 1'b0
`endif

module tb_sram_ctrl;
  localparam int AC = 2;
  localparam int WH = 1;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ce, oe, wbar, dir;
  logic [7:0]  dout, din;
  logic [18:0] saddr;

  always #5 clk = ~clk;

  sram_ctrl_if bus();

  sram_ctrl #(.ACCESS_CYCLES(AC), .WR_HOLD_CYCLES(WH)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .bus           (bus),
    .sram_ce_bar   (ce),
    .sram_oe_bar   (oe),
    .sram_we_bar   (wbar),
    .sram_data_dir (dir),
    .sram_data_out (dout),
    .sram_data_in  (din),
    .sram_addr     (saddr)
  );

  // Physical SRAM contents (written only by DUT strobes) and the reference image.
  logic [7:0] mem     [0:524287];
  logic [7:0] ref_mem [0:524287];
  int         we_rises = 0;
  logic       we_prev  = 1'b1;
  int         errors   = 0;
  int         checks   = 0;

  assign din = (!ce && !oe) ? mem[saddr] : 8'h00;

  // Byte is latched on the rising edge of WE_n while the chip is selected.
  always @(negedge clk) begin
    if (!we_prev && wbar && !ce) begin
      mem[saddr] = dout;
      we_rises   = we_rises + 1;
    end
    we_prev = wbar;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
  endfunction

  function automatic bit misaligned(input logic [1:0] size, input logic [18:0] addr);
`ifdef SRAM_CTRL_ALIGN_CHK_EN
    return (size == 2'd1 && addr[0]) || (size >= 2'd2 && addr[1:0] != 2'd0);
`else
    return 1'b0;
`endif
  endfunction

  // Must be called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_txn(input bit we, input logic [1:0] size, input logic [18:0] addr,
                         input logic [31:0] wdata, input string tag);
    int          n;
    bit          merr;
    int          exp_lat;
    logic [31:0] exp_rd;
    logic [18:0] a;
    int          lat, oe_cyc, we_cyc, ce_cyc, rises0, excl_bad;
    bit          got_ready;
    logic [31:0] got_rd;
    logic        got_err;

    n        = nbytes(size);
    merr     = misaligned(size, addr);
    exp_rd   = 32'd0;
    lat      = 0;
    oe_cyc   = 0;
    we_cyc   = 0;
    ce_cyc   = 0;
    excl_bad = 0;
    got_ready = 1'b0;
    got_rd   = 32'd0;
    got_err  = 1'b0;
    rises0   = we_rises;
    if (merr) exp_lat = 1;
    else      exp_lat = we ? n * (AC + WH + 1) + 1 : n * AC + 1;
    if (!merr) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 19'(i);
        if (we) ref_mem[a] = wdata[8*i +: 8];
        else    exp_rd[8*i +: 8] = ref_mem[a];
      end
    end

    bus.req = 1'b1; bus.we = we; bus.size = size; bus.addr = addr; bus.wdata = wdata;
    @(posedge clk);
    while (lat < exp_lat + 20) begin
      @(negedge clk);
      lat = lat + 1;
      if (!oe)   oe_cyc = oe_cyc + 1;
      if (!wbar) we_cyc = we_cyc + 1;
      if (!ce)   ce_cyc = ce_cyc + 1;
      if (!oe && dir == `IOR_DIR_OUT) excl_bad = excl_bad + 1;
      if (!we && dir == `IOR_DIR_OUT) excl_bad = excl_bad + 1;
      if (bus.ready) begin
        got_ready = 1'b1;
        got_rd    = bus.rdata;
        got_err   = bus.err;
        break;
      end
      // Bus noise while busy must be ignored.
      bus.addr  = 19'($urandom);
      bus.wdata = $urandom;
      bus.we    = 1'($urandom);
      bus.size  = 2'($urandom);
    end
    bus.req = 1'b0;

    check_eq({tag, "_ready"}, 32'(got_ready), 32'd1);
    check_eq({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_eq({tag, "_rdata"}, got_rd, exp_rd);
    check_eq({tag, "_err"}, 32'(got_err), 32'(merr));
    check_eq({tag, "_bus_safety"}, 32'(excl_bad), 32'd0);
    check_eq({tag, "_oe_cycles"}, 32'(oe_cyc), (merr || we) ? 32'd0 : 32'(n * AC));
    check_eq({tag, "_we_cycles"}, 32'(we_cyc), (!merr && we) ? 32'(n * AC) : 32'd0);
    check_eq({tag, "_ce_cycles"}, 32'(ce_cyc), 32'(exp_lat - 1));
    check_eq({tag, "_we_strobes"}, 32'(we_rises - rises0), (!merr && we) ? 32'(n) : 32'd0);
    if (we && !merr) begin
      for (int i = 0; i < n; i++) begin
        a = addr + 19'(i);
        check_eq({tag, "_membyte"}, {13'd0, a, mem[a]}, {13'd0, a, ref_mem[a]});
      end
    end
    @(negedge clk);
    check_eq({tag, "_ready_pulse"}, 32'(bus.ready), 32'd0);
  endtask

  task automatic check_pins_reset(input string tag);
    check_eq({tag, "_ce"},    32'(ce),    32'd1);
    check_eq({tag, "_oe"},    32'(oe),    32'd1);
    check_eq({tag, "_we"},    32'(wbar),  32'd1);
    check_eq({tag, "_dir"},   32'(dir),   32'(`IOR_DIR_IN));
    check_eq({tag, "_dout"},  32'(dout),  32'd0);
    check_eq({tag, "_addr"},  32'(saddr), 32'd0);
    check_eq({tag, "_ready"}, 32'(bus.ready), 32'd0);
    check_eq({tag, "_rdata"}, bus.rdata, 32'd0);
    check_eq({tag, "_err"},   32'(bus.err), 32'd0);
  endtask

  initial begin
    logic [7:0]  old3;
    int          ready_seen;
    bit          we_r;
    logic [1:0]  sz_r;
    logic [18:0] ad_r;

    bus.req = 1'b0; bus.we = 1'b0; bus.size = 2'd0; bus.addr = 19'd0; bus.wdata = 32'd0;
    for (int i = 0; i < 524288; i++) begin
      mem[i]     = 8'($urandom);
      ref_mem[i] = mem[i];
    end

    repeat (3) @(negedge clk);
    check_pins_reset("reset");
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    mem[19'h00010] = 8'hA5; ref_mem[19'h00010] = 8'hA5;
    run_txn(1'b0, 2'd0, 19'h00010, 32'd0, "byte_rd");
    run_txn(1'b1, 2'd2, 19'h00100, 32'h11223344, "word_wr");
    run_txn(1'b0, 2'd2, 19'h00100, 32'd0, "word_rd_back");

    mem[19'h7FFFE] = 8'h01; mem[19'h7FFFF] = 8'h02; mem[19'h00000] = 8'h03; mem[19'h00001] = 8'h04;
    ref_mem[19'h7FFFE] = 8'h01; ref_mem[19'h7FFFF] = 8'h02; ref_mem[19'h00000] = 8'h03; ref_mem[19'h00001] = 8'h04;
    run_txn(1'b0, 2'd2, 19'h7FFFE, 32'd0, "wrap_rd");

    run_txn(1'b1, 2'd1, 19'h00200, 32'h0000BEEF, "half_wr");
    run_txn(1'b0, 2'd1, 19'h00200, 32'd0, "half_rd");

    // Reset asserted while the third byte of a word write is being strobed.
    old3 = mem[19'h00303];
    bus.req = 1'b1; bus.we = 1'b1; bus.size = 2'd2; bus.addr = 19'h00300; bus.wdata = 32'hCAFEF00D;
    ready_seen = 0;
    @(posedge clk);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.ready) ready_seen = ready_seen + 1;
    end
    #2 rstn = 1'b0;
    #1 check_pins_reset("midrst");
    bus.req = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (bus.ready) ready_seen = ready_seen + 1;
    end
    check_eq("midrst_no_ready", 32'(ready_seen), 32'd0);
    check_eq("midrst_byte0", 32'(mem[19'h00300]), 32'h0D);
    check_eq("midrst_byte1", 32'(mem[19'h00301]), 32'hF0);
    check_eq("midrst_byte3", 32'(mem[19'h00303]), 32'(old3));
    ref_mem[19'h00300] = 8'h0D;
    ref_mem[19'h00301] = 8'hF0;
    ref_mem[19'h00302] = mem[19'h00302];
    run_txn(1'b0, 2'd2, 19'h00300, 32'd0, "post_rst_rd");

    run_txn(1'b0, 2'd2, 19'h00002, 32'd0, "misalign_rd");
    run_txn(1'b1, 2'd1, 19'h00401, 32'h00005A5A, "misalign_wr");

    for (int t = 0; t < 40; t++) begin
      we_r = 1'($urandom);
      sz_r = 2'($urandom);
      if ($urandom_range(0, 3) == 0) ad_r = 19'h7FFF8 + 19'($urandom_range(0, 7));
      else                           ad_r = 19'($urandom_range(0, 63));
      run_txn(we_r, sz_r, ad_r, $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
